// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared widths, funct3 codes, LSU state type and access helpers
package load_store_unit_pkg;

  localparam int XLEN = 32;
  localparam int ALEN = 32;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  typedef enum logic [2:0] {IDLE, LD_WAIT, LD_LO, LD_HI, ST_HI, DONE} lsu_state_e;

  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3)
      F3_HALF, F3_LHU: return 4'b0011;
      F3_WORD:         return 4'b1111;
      default:         return 4'b0001;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_HALF, F3_LHU: return off[0];
      F3_WORD:         return off != 2'b00;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [XLEN-1:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [15:0] get_halfword(input logic [XLEN-1:0] w, input logic idx);
    return w[{idx, 4'b0000} +: 16];
  endfunction

  function automatic logic [XLEN-1:0] sext8(input logic [7:0] b);
    return {{(XLEN-8){b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] zext8(input logic [7:0] b);
    return {{(XLEN-8){1'b0}}, b};
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] h);
    return {{(XLEN-16){h[15]}}, h};
  endfunction

  function automatic logic [XLEN-1:0] zext16(input logic [15:0] h);
    return {{(XLEN-16){1'b0}}, h};
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - pipeline request/response and data-memory port interfaces
interface lsu_req_if;
  import load_store_unit_pkg::*;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [ALEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface lsu_mem_if;
  import load_store_unit_pkg::*;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [2:0]      mem_funct3;
  logic [ALEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_we, mem_be, mem_funct3, mem_addr, mem_wdata, input mem_rdata);
  modport slave  (input mem_we, mem_be, mem_funct3, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/load_store_unit_load_merge.sv
// rtl/load_store_unit_load_merge.sv - lsu_load_merge: joins two word reads into one extended load
// result; used only when LSU_MISALIGNED_SPLIT_EN is defined.
module lsu_load_merge
  import load_store_unit_pkg::*;
(
  input  logic [2*XLEN-1:0] data,
  input  logic [1:0]        off,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   result
);
  logic [XLEN-1:0] win;

  assign win = data[{off, 3'b000} +: XLEN];

  always_comb begin
    result = win;
    case (funct3)
      F3_BYTE: result = sext8(get_byte(win, 2'd0));
      F3_LBU:  result = zext8(get_byte(win, 2'd0));
      F3_HALF: result = sext16(get_halfword(win, 1'b0));
      F3_LHU:  result = zext16(get_halfword(win, 1'b0));
      default: result = win;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator; LSU_MISALIGNED_SPLIT_EN enables
// splitting misaligned accesses into two word beats instead of reporting an error.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);
  lsu_state_e state_q, state_d;
  logic       err_q, err_d;
  logic [1:0] off;
  logic       misaligned, accept;

  assign off           = req.req_addr[1:0];
  assign misaligned    = is_misaligned(req.req_funct3, off);
  assign req.req_ready = (state_q == IDLE) && !rst;
  assign accept        = req.req_valid && req.req_ready;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [2:0]      funct3_q;
  logic [ALEN-1:0] addr_q, hi_addr;
  logic [XLEN-1:0] wdata_q, lo_q, merged;
  logic [7:0]      mask_acc, mask_q;

  assign mask_acc = {4'b0000, size_mask(req.req_funct3)} << off;
  assign mask_q   = {4'b0000, size_mask(funct3_q)} << addr_q[1:0];
  // Wraps modulo 2^ALEN on purpose: a split at the top of memory continues at address 0.
  assign hi_addr  = {addr_q[ALEN-1:2], 2'b00} + ALEN'(4);

  always_ff @(posedge clk) begin
    if (accept) begin
      funct3_q <= req.req_funct3;
      addr_q   <= req.req_addr;
      wdata_q  <= req.req_wdata;
    end
    if (state_q == LD_LO) lo_q <= mem.mem_rdata;
  end

  lsu_load_merge u_merge (
    .data   ({mem.mem_rdata, lo_q}),
    .off    (addr_q[1:0]),
    .funct3 (funct3_q),
    .result (merged)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    err_d          = err_q;
    mem.mem_we     = 1'b0;
    mem.mem_be     = 4'b0000;
    mem.mem_funct3 = req.req_funct3;
    mem.mem_addr   = req.req_addr;
    mem.mem_wdata  = req.req_wdata;
    req.rsp_valid  = 1'b0;
    req.rsp_rdata  = '0;
    req.rsp_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d = 1'b0;
          if (!misaligned) begin
            mem.mem_we = req.req_we;
            mem.mem_be = size_mask(req.req_funct3) << off;
            state_d    = req.req_we ? DONE : LD_WAIT;
          end else begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            mem.mem_funct3 = F3_WORD;
            if (req.req_we) begin
              mem.mem_we = 1'b1;
              mem.mem_be = mask_acc[3:0];
              state_d    = ST_HI;
            end else begin
              mem.mem_addr = {req.req_addr[ALEN-1:2], 2'b00};
              mem.mem_be   = 4'b1111;
              state_d      = LD_LO;
            end
`else
            err_d   = 1'b1;
            state_d = DONE;
`endif
          end
        end
      end
      LD_WAIT: begin
        req.rsp_valid = 1'b1;
        req.rsp_rdata = mem.mem_rdata;
        state_d       = IDLE;
      end
      DONE: begin
        req.rsp_valid = 1'b1;
        req.rsp_err   = err_q;
        state_d       = IDLE;
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      ST_HI: begin
        // The hi beat is issued even when its byte mask is empty.
        mem.mem_we     = 1'b1;
        mem.mem_funct3 = F3_WORD;
        mem.mem_addr   = hi_addr;
        mem.mem_be     = mask_q[7:4];
        mem.mem_wdata  = wdata_q >> {3'd4 - {1'b0, addr_q[1:0]}, 3'b000};
        state_d        = DONE;
      end
      LD_LO: begin
        mem.mem_funct3 = F3_WORD;
        mem.mem_addr   = hi_addr;
        mem.mem_be     = 4'b1111;
        state_d        = LD_HI;
      end
      LD_HI: begin
        req.rsp_valid = 1'b1;
        req.rsp_rdata = merged;
        state_d       = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (rst) begin
      mem.mem_we    = 1'b0;
      mem.mem_be    = 4'b0000;
      req.rsp_valid = 1'b0;
      req.rsp_rdata = '0;
      req.rsp_err   = 1'b0;
    end
  end
endmodule
